// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N:1 stream mux with round-robin or fixed-priority grant
// and a one-entry registered output stage.
module rr_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_en;
  logic [SELW-1:0]  start;
  logic             hi_valid, lo_valid, grant_valid;
  logic [SELW-1:0]  hi_idx, lo_idx, grant_idx;
  logic [WIDTH-1:0] grant_data;

  assign load_en = !valid_q || out_ready;

  // Rotating search split in two: lowest valid at or above the start index,
  // falling back to the lowest valid overall (the wrapped part of the ring).
  always_comb begin
    start    = mode ? '0 : ptr_q;
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_valid = 1'b1;
        lo_idx   = SELW'(i);
        if (SELW'(i) >= start) begin
          hi_valid = 1'b1;
          hi_idx   = SELW'(i);
        end
      end
    end
    grant_valid = lo_valid;
    grant_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !rst && load_en && grant_valid;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = grant_data;
        sel_d  = grant_idx;
        if (!mode) begin
          ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule
